jk_bank_sequencer: RTL and testbench

Command-driven controller that sequences a bank of WIDTH JK flip-flops. It accepts one command at a time over a valid/ready handshake. For a programmed number of clock edges it drives each cell's J/K so that the bank holds, sets, clears, toggles, counts up or down, or shifts left. It signals completion with a one-cycle done pulse. The block sits between a control host and the JK storage cells it owns.

---
 rtl/jk_seq_pkg.sv | 22 ++
 rtl/jk_bank_sequencer_if.sv | 42 ++++
 rtl/jk_cell.sv | 26 ++
 rtl/jk_bank_sequencer.sv | 161 ++++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jk_seq_pkg.sv
// Shared op codes, widths and FSM encoding for the JK bank sequencer.
// Optional feature macro used by this block: JK_SEQ_ABORT_EN.
package jk_seq_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD       = 3'd0;
  localparam logic [OP_W-1:0] OP_SET        = 3'd1;
  localparam logic [OP_W-1:0] OP_CLEAR      = 3'd2;
  localparam logic [OP_W-1:0] OP_TOGGLE     = 3'd3;
  localparam logic [OP_W-1:0] OP_COUNT_UP   = 3'd4;
  localparam logic [OP_W-1:0] OP_COUNT_DOWN = 3'd5;
  localparam logic [OP_W-1:0] OP_SHIFT_L    = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD       = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Command/status bundle between a control host and the JK bank sequencer.
// With JK_SEQ_ABORT_EN defined the bundle also carries abort/aborted.
interface jk_bank_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  import jk_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_bar;
  logic             busy;
  logic             done;
  logic             err;
`ifdef JK_SEQ_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  modport master (
`ifdef JK_SEQ_ABORT_EN
    output abort,
    input  aborted,
`endif
    output cmd_valid, cmd_op, cmd_mask, cmd_count,
    input  cmd_ready, Q, Q_bar, busy, done, err
  );

  modport slave (
`ifdef JK_SEQ_ABORT_EN
    input  abort,
    output aborted,
`endif
    input  cmd_valid, cmd_op, cmd_mask, cmd_count,
    output cmd_ready, Q, Q_bar, busy, done, err
  );

endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to Q=0.
module jk_cell (
  input  logic CLK,
  input  logic Reset,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_bar
);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

  assign Q_bar = ~Q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer driving J/K of a bank of WIDTH JK cells for a repeat count.
// Optional abort path enabled by defining JK_SEQ_ABORT_EN.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic CLK,
  input logic Reset,
  jk_bank_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             abort_hit;

  logic [WIDTH-1:0] q, qb, j, k;
  logic [WIDTH-1:0] run_j, run_k;
  logic [WIDTH-1:0] carry_up, carry_dn, q_shl;

`ifdef JK_SEQ_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  // State and command latches
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      mask_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
`ifdef JK_SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
`ifdef JK_SEQ_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // Next state, latches and gating of J/K onto the cells
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    err_d   = err_q;
    j       = '0;
    k       = '0;
`ifdef JK_SEQ_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = ST_RUN;
          op_d    = bus.cmd_op;
          mask_d  = bus.cmd_mask;
          rem_d   = (bus.cmd_count == '0) ? CNT_W'(1) : bus.cmd_count;
          err_d   = (bus.cmd_op == OP_RSVD);
        end
      end
      ST_RUN: begin
        if (abort_hit) begin
          state_d = ST_DONE;
`ifdef JK_SEQ_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else begin
          j     = run_j;
          k     = run_k;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ripple enables for counting: bit i moves only when all lower bits are 1 (up) or 0 (down)
  always_comb begin : carry_chain
    logic cu;
    logic cd;
    cu = 1'b1;
    cd = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      carry_up[i] = cu;
      carry_dn[i] = cd;
      cu = cu & q[i];
      cd = cd & qb[i];
    end
  end

  assign q_shl = q << 1;

  always_comb begin
    run_j = '0;
    run_k = '0;
    case (op_q)
      OP_SET:        run_j = mask_q;
      OP_CLEAR:      run_k = mask_q;
      OP_TOGGLE: begin
        run_j = mask_q;
        run_k = mask_q;
      end
      OP_COUNT_UP: begin
        run_j = mask_q & carry_up;
        run_k = mask_q & carry_up;
      end
      OP_COUNT_DOWN: begin
        run_j = mask_q & carry_dn;
        run_k = mask_q & carry_dn;
      end
      OP_SHIFT_L: begin
        run_j = mask_q & q_shl;
        run_k = mask_q & ~q_shl;
      end
      default: begin
        run_j = '0;
        run_k = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
    jk_cell u_cell (
      .CLK   (CLK),
      .Reset (Reset),
      .J     (j[gi]),
      .K     (k[gi]),
      .Q     (q[gi]),
      .Q_bar (qb[gi])
    );
  end

  assign bus.Q         = q;
  assign bus.Q_bar     = qb;
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = err_q;
`ifdef JK_SEQ_ABORT_EN
  assign bus.aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Scoreboard bench for jk_bank_sequencer; covers the abort path when JK_SEQ_ABORT_EN is defined.
module tb_jk_bank_sequencer;
  import jk_seq_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  jk_bank_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] q;
    int         busy;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] model_q;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  int         obs_busy, obs_rlow;
  logic       obs_seen, obs_err;
  logic [3:0] obs_q, obs_qb;

  // Reference behaviour written arithmetically rather than per cell
  function automatic logic [3:0] model(input logic [2:0] op, input logic [3:0] m,
                                       input logic [3:0] q0, input logic [7:0] cnt);
    logic [3:0] q;
    logic [3:0] t;
    int n;
    q = q0;
    n = (cnt == 8'd0) ? 1 : int'(cnt);
    for (int s = 0; s < n; s++) begin
      case (op)
        OP_SET:        q = q | m;
        OP_CLEAR:      q = q & ~m;
        OP_TOGGLE:     q = q ^ m;
        OP_COUNT_UP:   begin t = q + 4'd1; q = q ^ ((t ^ q) & m); end
        OP_COUNT_DOWN: begin t = q - 4'd1; q = q ^ ((t ^ q) & m); end
        OP_SHIFT_L:    q = ((q << 1) & m) | (q & ~m);
        default:       q = q;
      endcase
    end
    return q;
  endfunction

  task automatic send_cmd(input logic [2:0] op, input logic [3:0] m, input logic [7:0] cnt);
    exp_t x;
    @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_mask  = m;
    bus.cmd_count = cnt;
    @(posedge CLK);
    #1;
    bus.cmd_valid = 1'b0;
    x.q    = model(op, m, model_q, cnt);
    x.busy = (cnt == 8'd0) ? 1 : int'(cnt);
    x.err  = (op == OP_RSVD);
    model_q = x.q;
    sb.push_back(x);
  endtask

  // Collects busy/ready-low cycles and the state seen in the done cycle
  task automatic wait_done();
    obs_busy = 0;
    obs_rlow = 0;
    obs_seen = 1'b0;
    obs_q    = 'x;
    obs_qb   = 'x;
    obs_err  = 1'bx;
    for (int c = 0; c < 300 && !obs_seen; c++) begin
      @(negedge CLK);
      if (!bus.cmd_ready) obs_rlow++;
      if (bus.done) begin
        obs_seen = 1'b1;
        obs_q    = bus.Q;
        obs_qb   = bus.Q_bar;
        obs_err  = bus.err;
      end else if (bus.busy) begin
        obs_busy++;
      end
    end
  endtask

  task automatic load_q(input logic [3:0] target);
    send_cmd(OP_CLEAR, ~target, 8'd1);
    wait_done();
    e = sb.pop_front();
    total_cnt++;
    if (!obs_seen || obs_q !== e.q) $display("FAIL load_clear: seen=%0b got %b want %b", obs_seen, obs_q, e.q);
    else pass_cnt++;
    send_cmd(OP_SET, target, 8'd1);
    wait_done();
    e = sb.pop_front();
    total_cnt++;
    if (!obs_seen || obs_q !== e.q) $display("FAIL load_set: seen=%0b got %b want %b", obs_seen, obs_q, e.q);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    send_cmd(OP_SET, 4'b0011, 8'd1);
    wait_done();
    void'(sb.pop_front());
    @(negedge CLK);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    model_q = 4'b0000;
    total_cnt++; if (bus.Q !== 4'b0000) $display("FAIL reset_q: got %b want 0000", bus.Q); else pass_cnt++;
    total_cnt++; if (bus.Q_bar !== 4'b1111) $display("FAIL reset_qbar: got %b want 1111", bus.Q_bar); else pass_cnt++;
    total_cnt++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else pass_cnt++;
  endtask

  task automatic test_set();
    send_cmd(OP_SET, 4'b1010, 8'd0);
    wait_done();
    e = sb.pop_front();
    total_cnt++; if (obs_seen !== 1'b1) $display("FAIL set_done_seen: got %b want 1", obs_seen); else pass_cnt++;
    total_cnt++; if (obs_q !== e.q) $display("FAIL set_q: got %b want %b", obs_q, e.q); else pass_cnt++;
    total_cnt++; if (obs_qb !== ~e.q) $display("FAIL set_qbar: got %b want %b", obs_qb, ~e.q); else pass_cnt++;
    total_cnt++; if (obs_busy != e.busy) $display("FAIL set_busy_cycles: got %0d want %0d", obs_busy, e.busy); else pass_cnt++;
    total_cnt++; if (obs_rlow != e.busy + 1) $display("FAIL set_ready_low: got %0d want %0d", obs_rlow, e.busy + 1); else pass_cnt++;
    total_cnt++; if (obs_err !== e.err) $display("FAIL set_err: got %b want %b", obs_err, e.err); else pass_cnt++;
`ifdef JK_SEQ_ABORT_EN
    total_cnt++; if (bus.aborted !== 1'b0) $display("FAIL set_aborted: got %b want 0", bus.aborted); else pass_cnt++;
`endif
    @(negedge CLK);
    total_cnt++;
    if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1)
      $display("FAIL set_done_width: done=%b ready=%b want done=0 ready=1", bus.done, bus.cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_count_wrap();
    load_q(4'b0000);
    send_cmd(OP_COUNT_UP, 4'b1111, 8'd5);
    wait_done();
    e = sb.pop_front();
    total_cnt++; if (obs_q !== e.q) $display("FAIL up5_q: got %b want %b", obs_q, e.q); else pass_cnt++;
    total_cnt++; if (obs_busy != e.busy) $display("FAIL up5_busy: got %0d want %0d", obs_busy, e.busy); else pass_cnt++;
    load_q(4'b1110);
    send_cmd(OP_COUNT_UP, 4'b1111, 8'd3);
    wait_done();
    e = sb.pop_front();
    total_cnt++; if (obs_q !== e.q) $display("FAIL up_wrap_q: got %b want %b", obs_q, e.q); else pass_cnt++;
    total_cnt++; if (obs_busy != e.busy) $display("FAIL up_wrap_busy: got %0d want %0d", obs_busy, e.busy); else pass_cnt++;
    load_q(4'b0000);
    send_cmd(OP_COUNT_DOWN, 4'b1111, 8'd1);
    wait_done();
    e = sb.pop_front();
    total_cnt++; if (obs_q !== e.q) $display("FAIL down_wrap_q: got %b want %b", obs_q, e.q); else pass_cnt++;
    total_cnt++; if (obs_qb !== ~e.q) $display("FAIL down_wrap_qbar: got %b want %b", obs_qb, ~e.q); else pass_cnt++;
  endtask

  task automatic test_toggle_shift();
    load_q(4'b1010);
    send_cmd(OP_TOGGLE, 4'b0110, 8'd2);
    wait_done();
    e = sb.pop_front();
    total_cnt++; if (obs_q !== e.q) $display("FAIL toggle2_q: got %b want %b", obs_q, e.q); else pass_cnt++;
    send_cmd(OP_TOGGLE, 4'b0110, 8'd3);
    wait_done();
    e = sb.pop_front();
    total_cnt++; if (obs_q !== e.q) $display("FAIL toggle3_q: got %b want %b", obs_q, e.q); else pass_cnt++;
    load_q(4'b1011);
    send_cmd(OP_SHIFT_L, 4'b1111, 8'd1);
    wait_done();
    e = sb.pop_front();
    total_cnt++; if (obs_q !== e.q) $display("FAIL shift_q: got %b want %b", obs_q, e.q); else pass_cnt++;
    total_cnt++; if (obs_busy != e.busy) $display("FAIL shift_busy: got %0d want %0d", obs_busy, e.busy); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    load_q(4'b0000);
    send_cmd(OP_COUNT_UP, 4'b1111, 8'd10);
    @(negedge CLK);
    @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SET;
    bus.cmd_mask  = 4'b1111;
    bus.cmd_count = 8'd1;
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    total_cnt++; if (bus.Q !== 4'b0010) $display("FAIL run_ignore_valid_q: got %b want 0010", bus.Q); else pass_cnt++;
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    sb.delete();
    model_q = 4'b0000;
    total_cnt++; if (bus.Q !== 4'b0000) $display("FAIL midrun_reset_q: got %b want 0000", bus.Q); else pass_cnt++;
    total_cnt++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL midrun_reset_state: ready=%b busy=%b done=%b want 1 0 0", bus.cmd_ready, bus.busy, bus.done);
    else pass_cnt++;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (bus.done) saw_done = 1'b1;
    end
    total_cnt++; if (saw_done !== 1'b0) $display("FAIL midrun_reset_no_done: got %b want 0", saw_done); else pass_cnt++;
  endtask

  task automatic test_reserved();
    load_q(4'b0101);
    send_cmd(OP_RSVD, 4'b1111, 8'd2);
    wait_done();
    e = sb.pop_front();
    total_cnt++; if (obs_q !== e.q) $display("FAIL rsvd_q: got %b want %b", obs_q, e.q); else pass_cnt++;
    total_cnt++; if (obs_busy != e.busy) $display("FAIL rsvd_busy: got %0d want %0d", obs_busy, e.busy); else pass_cnt++;
    total_cnt++; if (obs_err !== e.err) $display("FAIL rsvd_err: got %b want %b", obs_err, e.err); else pass_cnt++;
    repeat (3) @(negedge CLK);
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL rsvd_err_sticky: got %b want 1", bus.err); else pass_cnt++;
    send_cmd(OP_HOLD, 4'b1111, 8'd1);
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL err_clear_on_accept: got %b want 0", bus.err); else pass_cnt++;
    wait_done();
    e = sb.pop_front();
    total_cnt++; if (obs_q !== e.q) $display("FAIL hold_q: got %b want %b", obs_q, e.q); else pass_cnt++;
  endtask

`ifdef JK_SEQ_ABORT_EN
  task automatic test_abort();
    load_q(4'b0000);
    send_cmd(OP_COUNT_UP, 4'b1111, 8'd8);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
    void'(sb.pop_front());
    model_q = 4'b0010;
    total_cnt++; if (bus.Q !== 4'b0010) $display("FAIL abort_q: got %b want 0010", bus.Q); else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b1 || bus.aborted !== 1'b1)
      $display("FAIL abort_flags: done=%b aborted=%b want 1 1", bus.done, bus.aborted);
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if (bus.done !== 1'b0 || bus.aborted !== 1'b0 || bus.cmd_ready !== 1'b1)
      $display("FAIL abort_after: done=%b aborted=%b ready=%b want 0 0 1", bus.done, bus.aborted, bus.cmd_ready);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_HOLD;
    bus.cmd_mask  = '0;
    bus.cmd_count = '0;
`ifdef JK_SEQ_ABORT_EN
    bus.abort     = 1'b0;
`endif
    model_q = 4'b0000;
    Reset   = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;

    test_reset();
    test_set();
    test_count_wrap();
    test_toggle_shift();
    test_reset_abort();
    test_reserved();
`ifdef JK_SEQ_ABORT_EN
    test_abort();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
